// File: rtl/uart_pkg.sv
// Shared UART constants and the receiver state type.
package uart_pkg;

  // Clocks per bit and per half bit at the system clock / baud ratio in use.
  localparam logic [11:0] BIT_TIME = 12'hA2C;  // 2604
  localparam logic [11:0] HALF_BIT = 12'h516;  // 1302

  // The transmitter's baud divider is the same bit period.
  localparam logic [11:0] TX_BAUD_DIV = BIT_TIME;

  // Receiver states; exposed as uart_rx.state for probing.
  typedef enum logic {
    RX_IDLE    = 1'b0,
    RX_RECEIVE = 1'b1
  } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous, idle-high line.
// Both flops preset to 1 so reset never looks like a line-low event.
module uart_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out
);

  logic [1:0] sync_ff;

  // Shift the raw line through two flops; first stage may go metastable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_ff <= 2'b11;
    else        sync_ff <= {sync_ff[0], async_in};
  end

  assign sync_out = sync_ff[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1, LSB first, start detect on a synchronized falling edge,
// every bit sampled at its centre.
// Optional stop-bit checking (frm_err port) is built when the macro
// UART_RX_FRAME_ERR_EN is defined; otherwise the stop bit is ignored.
//
// Handshake: rdy is the valid flag for rx_data. It rises one clk after the
// stop bit is sampled and stays high until the consumer pulses clr_rdy or a
// new start bit is detected. If setting and clearing land in the same clk,
// the set wins. rx_data holds steady while rdy is high; a byte that completes
// while rdy is still high simply overwrites rx_data.
module uart_rx
  import uart_pkg::*;
#(
  parameter logic [11:0] BIT_CLKS  = BIT_TIME,
  parameter logic [11:0] HALF_CLKS = HALF_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy
`ifdef UART_RX_FRAME_ERR_EN
  ,
  output logic       frm_err
`endif
);

  rx_state_t   state;
  logic        rx_sync;
  logic        rx_prev;
  logic [1:0]  warm_cnt;
  logic [11:0] baud_cnt;
  logic [3:0]  bit_cnt;
  logic [8:0]  shift_reg;
  logic        done;
  logic        start_det;

  uart_sync2 u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (RX),
    .sync_out (rx_sync)
  );

  // Previous-sample flop for edge detection. It is held at 0 until the
  // synchronizer has flushed its preset 1s, so a line that is already low when
  // reset releases never produces an edge; only a real 1 -> 0 transition does.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warm_cnt <= 2'd0;
      rx_prev  <= 1'b0;
    end else begin
      if (warm_cnt != 2'd2) warm_cnt <= warm_cnt + 2'd1;
      rx_prev <= (warm_cnt == 2'd2) ? rx_sync : 1'b0;
    end
  end

  assign start_det = (state == RX_IDLE) && rx_prev && !rx_sync;

  // Receive FSM: half-bit wait to the start-bit centre, then one sample per
  // bit. The zero cycle of baud_cnt counts as one clk, so reloading with
  // BIT_CLKS-1 keeps the sample spacing at exactly BIT_CLKS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RX_IDLE;
      baud_cnt  <= 12'd0;
      bit_cnt   <= 4'd0;
      shift_reg <= 9'h1FF;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (start_det) begin
            state    <= RX_RECEIVE;
            baud_cnt <= HALF_CLKS;
            bit_cnt  <= 4'd0;
          end
        end
        RX_RECEIVE: begin
          if (baud_cnt == 12'd0) begin
            baud_cnt <= BIT_CLKS - 12'd1;
            if ((bit_cnt == 4'd0) && rx_sync) begin
              // Start bit gone by its centre: glitch, drop it untouched.
              state <= RX_IDLE;
            end else begin
              shift_reg <= {rx_sync, shift_reg[8:1]};
              bit_cnt   <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd9) begin
                state <= RX_IDLE;
                done  <= 1'b1;
              end
            end
          end else begin
            baud_cnt <= baud_cnt - 12'd1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  // Byte-available flag; completion takes priority over any clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      rdy <= 1'b0;
    else if (done)                   rdy <= 1'b1;
    else if (clr_rdy || start_det)   rdy <= 1'b0;
  end

`ifdef UART_RX_FRAME_ERR_EN
  // Stop-bit error flag, set and cleared alongside rdy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      frm_err <= 1'b0;
    else if (done)                   frm_err <= ~shift_reg[8];
    else if (clr_rdy || start_det)   frm_err <= 1'b0;
  end
`endif

  assign rx_data = shift_reg[7:0];

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx. One instance runs at the real baud constants (loopback
// latency, start glitch); a second runs with a short bit time for the
// frame-level scenarios and randomized traffic.
// Define UART_RX_FRAME_ERR_EN to also exercise the frm_err port.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int FB = 24;   // short bit time
  localparam int FH = 12;   // short half bit
  // Posedges from the RX fall (first posedge = 1) to rdy: two synchronizer
  // clks plus the edge-detect clk, then HALF + 9*BIT + 2.
  localparam int FULL_RISE = int'(HALF_BIT) + 9 * int'(BIT_TIME) + 2 + 3;
  localparam int FAST_RISE = FH + 9 * FB + 2 + 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       rx_full, clr_full, rdy_full;
  logic [7:0] rx_data_full;
  logic       rx_fast, clr_fast, rdy_fast;
  logic [7:0] rx_data_fast;
`ifdef UART_RX_FRAME_ERR_EN
  logic       frm_err_full, frm_err_fast;
`endif

  uart_rx dut_full (
    .clk     (clk),
    .rst_n   (rst_n),
    .RX      (rx_full),
    .clr_rdy (clr_full),
    .rx_data (rx_data_full),
    .rdy     (rdy_full)
`ifdef UART_RX_FRAME_ERR_EN
    ,
    .frm_err (frm_err_full)
`endif
  );

  uart_rx #(.BIT_CLKS(12'(FB)), .HALF_CLKS(12'(FH))) dut_fast (
    .clk     (clk),
    .rst_n   (rst_n),
    .RX      (rx_fast),
    .clr_rdy (clr_fast),
    .rx_data (rx_data_fast),
    .rdy     (rdy_fast)
`ifdef UART_RX_FRAME_ERR_EN
    ,
    .frm_err (frm_err_fast)
`endif
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int rise_cnt = 0;
  logic [8:0] exp_q[$];   // {expected frm_err, expected byte}
  logic [8:0] ev;
  logic       rdy_fast_q = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, expv, $time);
  endtask

  // Each rdy rise on the fast instance delivers the oldest expected frame.
  always @(negedge clk) begin
    if (rdy_fast === 1'b1 && rdy_fast_q !== 1'b1) begin
      rise_cnt++;
      if (exp_q.size() == 0) begin
        check("rdy_unexpected", 32'd1, 32'd0);
      end else begin
        ev = exp_q.pop_front();
        check("rx_data", 32'(rx_data_fast), 32'(ev[7:0]));
`ifdef UART_RX_FRAME_ERR_EN
        check("frm_err", 32'(frm_err_fast), 32'(ev[8]));
`endif
      end
    end
    rdy_fast_q = rdy_fast;
  end

  // ---------------- driver tasks ----------------
  task automatic set_line(input bit sel_full, input logic v);
    if (sel_full) rx_full = v;
    else          rx_fast = v;
  endtask

  // Start bit, 8 data bits LSB first, stop bit; call on a negedge.
  task automatic drive_frame(input bit sel_full, input logic [7:0] b,
                             input logic stop_bit, input int bt);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      set_line(sel_full, bits[i]);
      repeat (bt) @(negedge clk);
    end
  endtask

  task automatic pulse_clr_fast();
    clr_fast = 1'b1;
    @(negedge clk);
    clr_fast = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] b;
    logic       sb;
    int         gap;
    int         r0;
    logic [9:0] abort_bits;

    rst_n    = 1'b0;
    rx_full  = 1'b1;
    rx_fast  = 1'b1;
    clr_full = 1'b0;
    clr_fast = 1'b0;
    repeat (4) @(negedge clk);

    // Reset values.
    check("rst_rdy_full",  32'(rdy_full), 32'd0);
    check("rst_data_full", 32'(rx_data_full), 32'hFF);
    check("rst_rdy_fast",  32'(rdy_fast), 32'd0);
    check("rst_data_fast", 32'(rx_data_fast), 32'hFF);
    check("rst_state",     32'(dut_full.state), 32'(RX_IDLE));
`ifdef UART_RX_FRAME_ERR_EN
    check("rst_frm_err",   32'(frm_err_full), 32'd0);
`endif
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    // 400-clk low glitch: start is taken, then rejected at the half-bit sample.
    rx_full = 1'b0;
    repeat (400) @(negedge clk);
    check("glitch_taken", 32'(dut_full.state), 32'(RX_RECEIVE));
    rx_full = 1'b1;
    repeat (1400) @(negedge clk);
    check("glitch_state", 32'(dut_full.state), 32'(RX_IDLE));
    check("glitch_rdy",   32'(rdy_full), 32'd0);
    check("glitch_data",  32'(rx_data_full), 32'hFF);

    // Full-rate loopback of 8'hA5 with latency measurement.
    fork
      drive_frame(1'b1, 8'hA5, 1'b1, int'(BIT_TIME));
      begin
        int n;
        n = 0;
        while (rdy_full !== 1'b1 && n < 30000) begin
          @(posedge clk);
          n++;
          #1;
        end
        check("lb_latency", (n >= FULL_RISE - 1 && n <= FULL_RISE + 1) ? FULL_RISE : n,
              FULL_RISE);
        check("lb_data", 32'(rx_data_full), 32'hA5);
      end
    join
    repeat (4) @(negedge clk);
    check("lb_rdy_held", 32'(rdy_full), 32'd1);
    clr_full = 1'b1;
    @(negedge clk);
    clr_full = 1'b0;
    check("lb_clr", 32'(rdy_full), 32'd0);
    check("lb_data_kept", 32'(rx_data_full), 32'hA5);

    // Back-to-back 00 then FF, no idle gap, clr_rdy between frames.
    exp_q.push_back({1'b0, 8'h00});
    exp_q.push_back({1'b0, 8'hFF});
    r0 = rise_cnt;
    @(negedge clk);
    fork
      begin
        drive_frame(1'b0, 8'h00, 1'b1, FB);
        drive_frame(1'b0, 8'hFF, 1'b1, FB);
      end
      begin
        int n;
        n = 0;
        while (rise_cnt == r0 && n < 400) begin
          @(negedge clk);
          n++;
        end
        check("b2b_first_seen", 32'(rise_cnt - r0), 32'd1);
        pulse_clr_fast();
        check("b2b_clr", 32'(rdy_fast), 32'd0);
      end
    join
    repeat (4) @(negedge clk);
    check("b2b_rises", 32'(rise_cnt - r0), 32'd2);
    pulse_clr_fast();

    // clr_rdy in the same clk as the set: set wins.
    b = 8'($urandom_range(0, 255));
    exp_q.push_back({1'b0, b});
    fork
      drive_frame(1'b0, b, 1'b1, FB);
      begin
        repeat (FAST_RISE - 1) @(posedge clk);
        @(negedge clk);
        clr_fast = 1'b1;
        @(negedge clk);
        clr_fast = 1'b0;
        check("setwin_rdy", 32'(rdy_fast), 32'd1);
        pulse_clr_fast();
        check("setwin_clr", 32'(rdy_fast), 32'd0);
      end
    join
    repeat (3) @(negedge clk);

    // Reset during bit 4 of 8'h3C with the line then held low: nothing reported.
    abort_bits = {1'b1, 8'h3C, 1'b0};
    for (int i = 0; i < 5; i++) begin
      rx_fast = abort_bits[i];
      repeat ((i == 4) ? FB / 2 : FB) @(negedge clk);
    end
    rst_n   = 1'b0;
    rx_fast = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("abort_rdy",  32'(rdy_fast), 32'd0);
    check("abort_data", 32'(rx_data_fast), 32'hFF);
    repeat (2 * FB) @(negedge clk);
    check("abort_low_idle", 32'(dut_fast.state), 32'(RX_IDLE));
    check("abort_low_rdy",  32'(rdy_fast), 32'd0);
    rx_fast = 1'b1;
    repeat (FB) @(negedge clk);
    exp_q.push_back({1'b0, 8'h96});
    drive_frame(1'b0, 8'h96, 1'b1, FB);
    repeat (3) @(negedge clk);
    pulse_clr_fast();

`ifdef UART_RX_FRAME_ERR_EN
    // Stop bit forced low on 8'h55.
    exp_q.push_back({1'b1, 8'h55});
    drive_frame(1'b0, 8'h55, 1'b0, FB);
    rx_fast = 1'b1;
    repeat (3) @(negedge clk);
    check("ferr_rdy",  32'(rdy_fast), 32'd1);
    check("ferr_flag", 32'(frm_err_fast), 32'd1);
    check("ferr_data", 32'(rx_data_fast), 32'h55);
    pulse_clr_fast();
    check("ferr_clr_rdy",  32'(rdy_fast), 32'd0);
    check("ferr_clr_flag", 32'(frm_err_fast), 32'd0);
`endif

    // Randomized traffic: random bytes, gaps and consumer acknowledges.
    for (int i = 0; i < 16; i++) begin
      b   = 8'($urandom_range(0, 255));
      sb  = 1'b1;
`ifdef UART_RX_FRAME_ERR_EN
      sb  = ($urandom_range(0, 3) != 0);
`endif
      gap = $urandom_range(0, 30);
      if (!sb && gap < 4) gap = 4;
      exp_q.push_back({~sb, b});
      drive_frame(1'b0, b, sb, FB);
      rx_fast = 1'b1;
      for (int g = 0; g < gap; g++) begin
        clr_fast = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      clr_fast = 1'b0;
    end
    repeat (10) @(negedge clk);

    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
